// File: rtl/heart_pkg.sv
// Shared types and defaults for the heart tracker: game state encoding,
// heart count width and the default timing parameters.
package heart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2,
        WIN       = 2'd3
    } state_t;

    localparam int HEART_W = 6;

    localparam int DEF_MAX_HEARTS    = 5;
    localparam int DEF_INVULN_FRAMES = 60;
    localparam int DEF_BLINK_FRAMES  = 8;

endpackage

// File: rtl/heart_counter.sv
// One entity's heart count plus its frame-based invulnerability cooldown.
// Counts only move while `active`; `load` restarts the entity.
module heart_counter
    import heart_pkg::*;
#(
    parameter int MAX_HEARTS    = DEF_MAX_HEARTS,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int CD_W          = $clog2(INVULN_FRAMES + 1)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               load,
    input  logic [HEART_W-1:0] load_value,
    input  logic               active,
    input  logic               hit,
    input  logic               heal,
    input  logic               frame_tick,
    output logic [HEART_W-1:0] count,
    output logic               busy
);

    localparam logic [HEART_W-1:0] MAX_COUNT  = HEART_W'(MAX_HEARTS);
    localparam logic [HEART_W-1:0] COUNT_ONE  = HEART_W'(1);
    localparam logic [CD_W-1:0]    CD_LOAD    = CD_W'(INVULN_FRAMES);
    localparam logic [CD_W-1:0]    CD_ONE     = CD_W'(1);

    logic [CD_W-1:0] cooldown;
    logic            accept;

    // A hit landing on the same tick that clears the cooldown still sees it non-zero
    assign accept = active && hit && (count != '0) && (cooldown == '0);
    assign busy   = (cooldown != '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (accept) begin
            count <= count - COUNT_ONE;
        end else if (active && heal && (count < MAX_COUNT)) begin
            count <= count + COUNT_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || load) begin
            cooldown <= '0;
        end else if (accept) begin
            cooldown <= CD_LOAD;
        end else if (frame_tick && (cooldown != '0)) begin
            cooldown <= cooldown - CD_ONE;
        end
    end

endmodule

// File: rtl/heart_tracker.sv
// Owns player/enemy heart counts, resolves game over and win, and drives
// the heart display enables including the player invulnerability blink.
module heart_tracker
    import heart_pkg::*;
#(
    parameter int MAX_HEARTS    = DEF_MAX_HEARTS,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               game_start,
    input  logic               en2_present,
    input  logic               hit_player,
    input  logic               hit_en,
    input  logic               hit_en2,
    input  logic               heal_player,
    output logic [HEART_W-1:0] remaining_hearts,
    output logic [HEART_W-1:0] remaining_hearts_en,
    output logic [HEART_W-1:0] remaining_hearts_en2,
    output logic               heart_enable,
    output logic               enable12,
    output logic               player_dead,
    output logic               enemies_dead
);

    localparam int                 CD_W      = $clog2(INVULN_FRAMES + 1);
    localparam logic [HEART_W-1:0] MAX_COUNT = HEART_W'(MAX_HEARTS);
    localparam logic [CD_W-1:0]    BLINK_MAX = CD_W'(INVULN_FRAMES);
    localparam logic [CD_W-1:0]    BLINK_ONE = CD_W'(1);

    state_t              state;
    state_t              state_next;
    logic                frame_prev;
    logic                frame_tick;
    logic                playing;
    logic                start;
    logic                p_busy;
    logic                e_busy;
    logic                e2_busy;
    logic                p_accept;
    logic                enemies_out;
    logic                blink_odd;
    logic [CD_W-1:0]     blink_count;
    logic [HEART_W-1:0]  en2_load_value;
    logic                unused_busy;

    assign frame_tick     = frame_clk && !frame_prev;
    assign playing        = (state == PLAY);
    assign start          = game_start && !playing;
    assign en2_load_value = en2_present ? MAX_COUNT : '0;
    assign enemies_out    = (remaining_hearts_en == '0) &&
                            (!enable12 || (remaining_hearts_en2 == '0));
    assign unused_busy    = e_busy ^ e2_busy;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_prev <= 1'b0;
        end else begin
            frame_prev <= frame_clk;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Player death is checked first so a simultaneous wipe-out is a loss
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (game_start) state_next = PLAY;
            end
            PLAY: begin
                if (remaining_hearts == '0) begin
                    state_next = GAME_OVER;
                end else if (enemies_out) begin
                    state_next = WIN;
                end
            end
            GAME_OVER, WIN: begin
                if (game_start) state_next = PLAY;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            enable12 <= 1'b0;
        end else if (start) begin
            enable12 <= en2_present;
        end
    end

    heart_counter #(
        .MAX_HEARTS    (MAX_HEARTS),
        .INVULN_FRAMES (INVULN_FRAMES),
        .CD_W          (CD_W)
    ) u_player (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (start),
        .load_value (MAX_COUNT),
        .active     (playing),
        .hit        (hit_player),
        .heal       (heal_player),
        .frame_tick (frame_tick),
        .count      (remaining_hearts),
        .busy       (p_busy)
    );

    heart_counter #(
        .MAX_HEARTS    (MAX_HEARTS),
        .INVULN_FRAMES (INVULN_FRAMES),
        .CD_W          (CD_W)
    ) u_enemy (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (start),
        .load_value (MAX_COUNT),
        .active     (playing),
        .hit        (hit_en),
        .heal       (1'b0),
        .frame_tick (frame_tick),
        .count      (remaining_hearts_en),
        .busy       (e_busy)
    );

    heart_counter #(
        .MAX_HEARTS    (MAX_HEARTS),
        .INVULN_FRAMES (INVULN_FRAMES),
        .CD_W          (CD_W)
    ) u_enemy2 (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (start),
        .load_value (en2_load_value),
        .active     (playing),
        .hit        (hit_en2),
        .heal       (1'b0),
        .frame_tick (frame_tick),
        .count      (remaining_hearts_en2),
        .busy       (e2_busy)
    );

    // Mirrors the player accept condition so the blink restarts with each new cooldown
    assign p_accept = playing && hit_player && (remaining_hearts != '0) && !p_busy;

    always_ff @(posedge Clk) begin
        if (Reset || start || p_accept) begin
            blink_count <= '0;
        end else if (frame_tick && p_busy && (blink_count < BLINK_MAX)) begin
            blink_count <= blink_count + BLINK_ONE;
        end
    end

    assign blink_odd    = ((int'(blink_count) / BLINK_FRAMES) % 2) != 0;
    assign heart_enable = (state != IDLE) && !(playing && p_busy && blink_odd);
    assign player_dead  = (state == GAME_OVER);
    assign enemies_dead = (state == WIN);

endmodule

// File: doc/heart_tracker.md
# heart_tracker

Game-state block that owns the heart (life) counts for the player and up to two enemies, and drives the heart display mapper's `remaining_hearts`, `remaining_hearts_en`, `remaining_hearts_en2`, `heart_enable` and `enable12` inputs. It sits between the collision/hit logic and the heart mapper. It accepts single-cycle hit and heal pulses, applies per-entity invulnerability cooldowns counted in video frames, blinks the hearts during player invulnerability, and resolves game-over and win conditions.

## Interface
Parameters:
- `MAX_HEARTS`, 5: hearts loaded at game start, per entity; must be between 1 and 63.
- `INVULN_FRAMES`, 60: frames of hit immunity after each accepted hit.
- `BLINK_FRAMES`, 8: frames per blink half-period during player invulnerability.

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high reset.
- `frame_clk`  in  1  vertical-sync-rate level signal; its rising edge is detected internally.
- `game_start`  in  1  pulse that starts or restarts the game.
- `en2_present`  in  1  second enemy exists; sampled on an accepted `game_start`.
- `hit_player`, `hit_en`, `hit_en2`  in  1 each  single-cycle hit pulses.
- `heal_player`  in  1  single-cycle +1 heart pulse.
- `remaining_hearts`, `remaining_hearts_en`, `remaining_hearts_en2`  out  6 each  current heart counts.
- `heart_enable`  out  1  display enable for player and enemy rows.
- `enable12`  out  1  display enable for the second-enemy row.
- `player_dead`  out  1  high while in GAME_OVER.
- `enemies_dead`  out  1  high while in WIN.

## Operation
- `frame_tick`: rising edge of registered `frame_clk`, i.e. `frame_clk` high and its previous sample low. It is one `Clk` cycle wide.
- States: IDLE, PLAY, GAME_OVER, WIN.
  - IDLE: `game_start` goes to PLAY.
  - PLAY: player count 0 goes to GAME_OVER. All active enemies at 0 goes to WIN. If both conditions hold in the same cycle, GAME_OVER wins.
  - GAME_OVER / WIN: `game_start` restarts and goes to PLAY.
  - `game_start` in PLAY is ignored.
- Start or restart:
  - All active counts load `MAX_HEARTS`.
  - `remaining_hearts_en2` loads `MAX_HEARTS` only if `en2_present`, else 0.
  - `enable12` is set to `en2_present`.
  - All cooldowns clear to 0.
- Per-entity hit, in PLAY only:
  - A hit is accepted if the count is > 0 and the cooldown is 0.
  - An accepted hit decrements the count and loads the cooldown with `INVULN_FRAMES`.
  - A hit during cooldown, or at count 0, is dropped.
- Cooldown: decrements by 1 on each `frame_tick` while > 0, and saturates at 0.
- Heal: player count +1, saturating at `MAX_HEARTS`. It is ignored outside PLAY. If hit and heal arrive in the same cycle, the hit is applied and the heal is dropped.
- Counts freeze in GAME_OVER and WIN.
- `heart_enable`:
  - 0 in IDLE, 1 otherwise.
  - Exception: in PLAY while the player cooldown is > 0, it is 0 during odd blink phases.
  - Blink phase is `(INVULN_FRAMES - cooldown) / BLINK_FRAMES`, computed with a frame counter that resets on each accepted player hit.
- Enemy hits do not blink.
- Width rule: counts are 6-bit unsigned. Cooldown and blink counters are `$clog2(INVULN_FRAMES+1)` bits. No arithmetic ever wraps.

## Timing
- Reset values: state IDLE; all counts 0; all cooldowns 0; `heart_enable` 0; `enable12` 0; `player_dead` 0; `enemies_dead` 0.
- All outputs are registered.
- Latencies from an input pulse in cycle N:
  - Hit or heal: count changes in cycle N+1.
  - `game_start`: counts load and the state changes in N+1.
  - A count reaching 0 in N+1 gives the state change and `player_dead`/`enemies_dead` in N+2.
- Cooldown expiry: a hit in the same cycle as the `frame_tick` that takes the cooldown from 1 to 0 is still dropped. The next cycle accepts.
- Reset mid-game overrides every other input and returns to IDLE in the next cycle.

## Structure
- Package `heart_pkg`:
  - `state_t` enum (IDLE, PLAY, GAME_OVER, WIN).
  - `HEART_W = 6`.
  - Default parameter constants.
- Sub-module `heart_counter`, instantiated 3 times. It contains:
  - count register;
  - cooldown register;
  - hit-accept logic;
  - load/clear, heal and freeze inputs;
  - a `busy` output (cooldown > 0).
- Top level contains the FSM, the `frame_tick` edge detector, blink logic and the output flags.

## Test plan
All scenarios use `INVULN_FRAMES=4`, `BLINK_FRAMES=2`, `MAX_HEARTS=5`.
- Reset, then `game_start` with `en2_present=1` -> next cycle all counts 5, `enable12=1`, `heart_enable=1`, state PLAY.
- `hit_player`, then a second `hit_player` 2 frames later -> count 5→4, second hit dropped. After 4 `frame_tick`s, another hit gives 3. `heart_enable` is low during frames 2–3 of the cooldown.
- `hit_player` and `heal_player` in the same cycle at count 3 -> 2. A lone heal at count 5 -> stays 5.
- Drive player to 0 while `hit_en` takes the last enemy to 0 in the same cycle -> GAME_OVER, `player_dead=1`, `enemies_dead=0`, counts frozen.
- `en2_present=0`, enemy 1 driven to 0 -> WIN two cycles after the last hit, `remaining_hearts_en2=0`, `enable12=0`. `game_start` -> all active counts 5, PLAY.
- `Reset` asserted mid-cooldown in PLAY -> next cycle IDLE, counts 0, `heart_enable=0`. Hits ignored until `game_start`.
